// File: rtl/data_sram_resp.sv
// Data SRAM responder: byte-writable word memory, RD_LAT-deep read pipeline, window check.
// Define DSRAM_STATS_EN to add the read/write/error access counters.
module data_sram_resp #(
   parameter int          DEPTH_LOG2 = 14,
   parameter logic [31:0] BASE_ADDR  = 32'h1c00_0000,
   parameter int          RD_LAT     = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_we,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        rdata_valid,
   output logic        acc_err
`ifdef DSRAM_STATS_EN
   ,
   output logic [31:0] stat_rd_cnt,
   output logic [31:0] stat_wr_cnt,
   output logic [15:0] stat_err_cnt
`endif
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   generate
      if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
         $error("data_sram_resp: RD_LAT must be in 1..4");
      end
      if (BASE_ADDR[DEPTH_LOG2+1:0] != '0) begin : g_bad_base
         $error("data_sram_resp: BASE_ADDR not aligned to window size");
      end
   endgenerate

   logic [31:0]           mem [DEPTH];
   logic                  in_win;
   logic                  is_rd;
   logic                  is_wr;
   logic [DEPTH_LOG2-1:0] idx;
   logic                  unused_addr_lsbs;

   assign in_win = (data_sram_addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]);
   assign idx    = data_sram_addr[DEPTH_LOG2+1:2];
   assign is_rd  = data_sram_en && (data_sram_we == 4'h0);
   assign is_wr  = data_sram_en && (data_sram_we != 4'h0);
   // Lane selection comes from the byte strobes, so the low address bits carry nothing.
   assign unused_addr_lsbs = ^data_sram_addr[1:0];

   // Memory contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (is_wr && in_win) begin
         for (int i = 0; i < 4; i++) begin
            if (data_sram_we[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
         end
      end
   end

   logic [RD_LAT-1:0] pipe_v;
   logic [RD_LAT-1:0] pipe_e;
   logic [31:0]       pipe_d [RD_LAT];

   // Data stages only advance behind a valid read, so the last stage holds between responses.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         pipe_v <= '0;
         pipe_e <= '0;
         for (int k = 0; k < RD_LAT; k++) pipe_d[k] <= '0;
      end else begin
         pipe_v[0] <= is_rd;
         pipe_e[0] <= data_sram_en && !in_win;
         if (is_rd) pipe_d[0] <= in_win ? mem[idx] : 32'h0;
         for (int k = 1; k < RD_LAT; k++) begin
            pipe_v[k] <= pipe_v[k-1];
            pipe_e[k] <= pipe_e[k-1];
            if (pipe_v[k-1]) pipe_d[k] <= pipe_d[k-1];
         end
      end
   end

   assign data_sram_rdata = pipe_d[RD_LAT-1];
   assign rdata_valid     = pipe_v[RD_LAT-1];
   assign acc_err         = pipe_e[RD_LAT-1];

`ifdef DSRAM_STATS_EN
   always_ff @(posedge clk) begin
      if (!resetn) begin
         stat_rd_cnt  <= '0;
         stat_wr_cnt  <= '0;
         stat_err_cnt <= '0;
      end else begin
         if (is_rd) stat_rd_cnt <= stat_rd_cnt + 32'd1;
         if (is_wr) stat_wr_cnt <= stat_wr_cnt + 32'd1;
         if (data_sram_en && !in_win) stat_err_cnt <= stat_err_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: one RD_LAT=1 instance and one RD_LAT=3 instance
// sharing the same request stream.
module tb_data_sram_resp;

   logic        clk;
   logic        resetn;
   logic        en;
   logic [3:0]  we;
   logic [31:0] addr;
   logic [31:0] wdata;

   logic [31:0] rdata1, rdata3;
   logic        valid1, valid3;
   logic        err1, err3;
`ifdef DSRAM_STATS_EN
   logic [31:0] rd_cnt1, wr_cnt1, rd_cnt3, wr_cnt3;
   logic [15:0] err_cnt1, err_cnt3;
`endif

   int n_vec = 0;
   int n_err = 0;

   data_sram_resp #(.RD_LAT(1)) dut1 (
      .clk(clk), .resetn(resetn),
      .data_sram_en(en), .data_sram_we(we), .data_sram_addr(addr), .data_sram_wdata(wdata),
      .data_sram_rdata(rdata1), .rdata_valid(valid1), .acc_err(err1)
`ifdef DSRAM_STATS_EN
      , .stat_rd_cnt(rd_cnt1), .stat_wr_cnt(wr_cnt1), .stat_err_cnt(err_cnt1)
`endif
   );

   data_sram_resp #(.RD_LAT(3)) dut3 (
      .clk(clk), .resetn(resetn),
      .data_sram_en(en), .data_sram_we(we), .data_sram_addr(addr), .data_sram_wdata(wdata),
      .data_sram_rdata(rdata3), .rdata_valid(valid3), .acc_err(err3)
`ifdef DSRAM_STATS_EN
      , .stat_rd_cnt(rd_cnt3), .stat_wr_cnt(wr_cnt3), .stat_err_cnt(err_cnt3)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one request for exactly one clock, leave the bus idle afterwards.
   task automatic req(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
      en = e; we = w; addr = a; wdata = d;
      @(posedge clk); #1;
      en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0;
   endtask

   task automatic idle();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      idle(); idle();
      n_vec++;
      if (rdata1 !== 32'h0 || valid1 !== 1'b0 || err1 !== 1'b0) begin
         n_err++; $display("FAIL reset_lat1: rdata=%h valid=%b err=%b, want 0/0/0", rdata1, valid1, err1);
      end
      n_vec++;
      if (rdata3 !== 32'h0 || valid3 !== 1'b0 || err3 !== 1'b0) begin
         n_err++; $display("FAIL reset_lat3: rdata=%h valid=%b err=%b, want 0/0/0", rdata3, valid3, err3);
      end
      resetn = 1'b1;
      idle();
   endtask

   task automatic test_full_word();
      req(1'b1, 4'hF, 32'h1c00_0010, 32'hDEAD_BEEF);
      req(1'b1, 4'h0, 32'h1c00_0010, 32'h0);
      n_vec++;
      if (valid1 !== 1'b1 || rdata1 !== 32'hDEAD_BEEF || err1 !== 1'b0) begin
         n_err++; $display("FAIL full_word: valid=%b rdata=%h err=%b, want 1/deadbeef/0", valid1, rdata1, err1);
      end
      idle();
      n_vec++;
      if (valid1 !== 1'b0 || rdata1 !== 32'hDEAD_BEEF) begin
         n_err++; $display("FAIL rdata_hold: valid=%b rdata=%h, want 0/deadbeef", valid1, rdata1);
      end
   endtask

   task automatic test_byte_write();
      req(1'b1, 4'hF, 32'h1c00_0010, 32'h1122_3344);
      req(1'b1, 4'b1000, 32'h1c00_0013, 32'h5A5A_5A5A);
      req(1'b1, 4'h0, 32'h1c00_0010, 32'h0);
      n_vec++;
      if (valid1 !== 1'b1 || rdata1 !== 32'h5A22_3344) begin
         n_err++; $display("FAIL byte_write: valid=%b rdata=%h, want 1/5a223344", valid1, rdata1);
      end
   endtask

   task automatic test_half_write();
      req(1'b1, 4'hF, 32'h1c00_0020, 32'h1122_3344);
      req(1'b1, 4'b0011, 32'h1c00_0020, 32'hAAAA_7788);
      req(1'b1, 4'h0, 32'h1c00_0022, 32'h0);
      n_vec++;
      if (valid1 !== 1'b1 || rdata1 !== 32'h1122_7788) begin
         n_err++; $display("FAIL half_write: valid=%b rdata=%h, want 1/11227788", valid1, rdata1);
      end
   endtask

   task automatic test_out_of_window();
      req(1'b1, 4'h0, 32'h0000_0000, 32'h0);
      n_vec++;
      if (valid1 !== 1'b1 || rdata1 !== 32'h0 || err1 !== 1'b1) begin
         n_err++; $display("FAIL oow_read: valid=%b rdata=%h err=%b, want 1/0/1", valid1, rdata1, err1);
      end
      req(1'b1, 4'hF, 32'h0000_0000, 32'hFFFF_FFFF);
      n_vec++;
      if (valid1 !== 1'b0 || err1 !== 1'b1) begin
         n_err++; $display("FAIL oow_write: valid=%b err=%b, want 0/1", valid1, err1);
      end
      req(1'b0, 4'hF, 32'h1c00_0020, 32'hFFFF_FFFF);
      n_vec++;
      if (valid1 !== 1'b0 || err1 !== 1'b0) begin
         n_err++; $display("FAIL en_low: valid=%b err=%b, want 0/0", valid1, err1);
      end
      req(1'b1, 4'h0, 32'h1c00_0020, 32'h0);
      n_vec++;
      if (valid1 !== 1'b1 || rdata1 !== 32'h1122_7788 || err1 !== 1'b0) begin
         n_err++; $display("FAIL en_low_mem: valid=%b rdata=%h err=%b, want 1/11227788/0", valid1, rdata1, err1);
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0]  exp_v;
      logic [31:0] exp_d [6];
      exp_v = 6'b011100;
      exp_d = '{32'h0, 32'h0, 32'h1, 32'h2, 32'h3, 32'h3};
      req(1'b1, 4'hF, 32'h1c00_0100, 32'h1);
      req(1'b1, 4'hF, 32'h1c00_0104, 32'h2);
      req(1'b1, 4'hF, 32'h1c00_0108, 32'h3);
      for (int c = 0; c < 6; c++) begin
         if (c < 3) req(1'b1, 4'h0, 32'h1c00_0100 + 32'(4 * c), 32'h0);
         else idle();
         n_vec++;
         if (valid3 !== exp_v[c] || (c >= 2 && rdata3 !== exp_d[c])) begin
            n_err++;
            $display("FAIL back_to_back[%0d]: valid=%b rdata=%h, want %b/%h", c, valid3, rdata3, exp_v[c], exp_d[c]);
         end
      end
   endtask

   task automatic test_reset_midflight();
      int seen;
      seen = 0;
      req(1'b1, 4'h0, 32'h1c00_0100, 32'h0);
      resetn = 1'b0;
      idle();
      resetn = 1'b1;
      for (int c = 0; c < 5; c++) begin
         if (valid3 !== 1'b0 || err3 !== 1'b0) seen++;
         idle();
      end
      n_vec++;
      if (seen != 0) begin
         n_err++; $display("FAIL reset_midflight: %0d cycles with valid/err after reset, want 0", seen);
      end
`ifdef DSRAM_STATS_EN
      n_vec++;
      if (rd_cnt3 !== 32'h0 || wr_cnt3 !== 32'h0 || err_cnt3 !== 16'h0) begin
         n_err++; $display("FAIL stats_reset: rd=%0d wr=%0d err=%0d, want 0/0/0", rd_cnt3, wr_cnt3, err_cnt3);
      end
`endif
      req(1'b1, 4'hF, 32'h1c00_0200, 32'h77);
      req(1'b1, 4'h0, 32'h1c00_0200, 32'h0);
      req(1'b1, 4'h0, 32'h1c00_0100, 32'h0);
`ifdef DSRAM_STATS_EN
      n_vec++;
      if (rd_cnt3 !== 32'd2 || wr_cnt3 !== 32'd1 || err_cnt3 !== 16'd0) begin
         n_err++; $display("FAIL stats_count: rd=%0d wr=%0d err=%0d, want 2/1/0", rd_cnt3, wr_cnt3, err_cnt3);
      end
`endif
      idle();
      n_vec++;
      if (valid3 !== 1'b1 || rdata3 !== 32'h77) begin
         n_err++; $display("FAIL post_reset_read: valid=%b rdata=%h, want 1/00000077", valid3, rdata3);
      end
      idle();
      n_vec++;
      if (valid3 !== 1'b1 || rdata3 !== 32'h1) begin
         n_err++; $display("FAIL mem_kept: valid=%b rdata=%h, want 1/00000001", valid3, rdata3);
      end
   endtask

   initial begin
      resetn = 1'b0; en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0;
      #1;
      test_reset();
      test_full_word();
      test_byte_write();
      test_half_write();
      test_out_of_window();
      test_back_to_back();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
- Responder (slave) end of the data SRAM interface that the EX stage drives (`data_sram_en`, `data_sram_we`, `data_sram_addr`, `data_sram_wdata`).
- Implements a byte-writable word memory with a configurable read-latency pipeline, address-window checking and an error flag.
- Returns load data to the MEM stage; used as the simulation/FPGA data memory behind the pipeline.

Parameters:
- DEPTH_LOG2, 14, log2 of memory depth in 32-bit words (default 16K words = 64 KB).
- BASE_ADDR, 32'h1c00_0000, byte base address of the window; must be aligned to 2^(DEPTH_LOG2+2).
- RD_LAT, 1, read latency in cycles from request to `rdata_valid`; legal range 1..4.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous reset, active-low
- data_sram_en  in  1  request strobe
- data_sram_we  in  4  byte write strobes; 0 = read
- data_sram_addr  in  32  byte address
- data_sram_wdata  in  32  write data, already lane-replicated by the initiator
- data_sram_rdata  out  32  read data, full aligned word
- rdata_valid  out  1  read data valid, one-cycle pulse per read
- acc_err  out  1  out-of-window access flag, aligned with response timing

Behaviour:
- Clock: `clk`. Reset: `resetn`, synchronous, active-low.
- Reset values:
  - `data_sram_rdata` = 0, `rdata_valid` = 0, `acc_err` = 0.
  - All latency-pipeline valid bits = 0.
  - Memory array is NOT cleared by reset.
- Request classification, each cycle with `data_sram_en`=1:
  - write if `we`!=0;
  - read if `we`==0.
  - `en`=0: no action, regardless of `we`.
- Address decode:
  - in-window iff `addr[31:DEPTH_LOG2+2]` == `BASE_ADDR[31:DEPTH_LOG2+2]`;
  - word index = `addr[DEPTH_LOG2+1:2]`;
  - `addr[1:0]` is ignored (lane selection is encoded in `we`).
- Write, in-window:
  - at the clock edge, for each i with `we[i]`=1, `mem[idx][8i+7:8i]` <= `wdata[8i+7:8i]`;
  - bytes with `we[i]`=0 are unchanged;
  - no response is generated (`rdata_valid` stays 0).
- Write, out-of-window:
  - memory is unchanged;
  - `acc_err` pulses for one cycle, RD_LAT cycles after the request;
  - `rdata_valid` stays 0.
- Read:
  - the word is sampled at the request edge and propagates through an RD_LAT-deep pipeline;
  - `rdata_valid`=1 exactly RD_LAT cycles after the request cycle;
  - `data_sram_rdata` = sampled word (out-of-window: 0, with `acc_err`=1 in the same cycle).
- `data_sram_rdata` holds its last value while `rdata_valid`=0.
- Fully pipelined: one request per cycle is accepted, with no stalls and no backpressure.
- Ordering: a write in cycle n is visible to a read issued in cycle n+1 or later.
- Reset asserted mid-flight: all in-flight read responses and error responses are dropped, and no `rdata_valid` or `acc_err` pulse follows reset release. Writes already committed remain committed.
- RD_LAT outside 1..4: elaboration error.

Optional Feature:
- Macro: `DSRAM_STATS_EN`.
- Enabled, three extra outputs are added:
  - `stat_rd_cnt` [31:0]: count of reads accepted;
  - `stat_wr_cnt` [31:0]: count of writes accepted;
  - `stat_err_cnt` [15:0]: count of out-of-window accesses.
  - Counter rules: each counts at the request cycle; each wraps modulo its width; each is cleared to 0 by reset.
  - An out-of-window access also counts in `stat_rd_cnt` or `stat_wr_cnt`, according to its type.
- Disabled: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Full-word write/read (RD_LAT=1):
  - Stimulus: write `we`=4'hF, addr 0x1c000010, wdata 0xDEADBEEF; then read the same address next cycle.
  - Response: one cycle later, `rdata_valid`=1, `rdata`=0xDEADBEEF, `acc_err`=0.
- Byte write (st.b):
  - Stimulus: write `we`=4'b1000, wdata 0x5A5A5A5A to addr 0x1c000013 (word preloaded 0x11223344); then read.
  - Response: `rdata`=0x5A223344.
- Halfword write (st.h):
  - Stimulus: write `we`=4'b0011, wdata 0xAAAA7788 to a word preloaded 0x11223344; then read.
  - Response: `rdata`=0x11227788.
- Out-of-window and `en`=0:
  - Stimulus 1: read addr 0x00000000.
  - Response 1: `rdata_valid`=1, `rdata`=0, `acc_err`=1.
  - Stimulus 2: write with `en`=0, `we`=4'hF.
  - Response 2: memory unchanged, no `acc_err`.
- Back-to-back reads, RD_LAT=3:
  - Stimulus: reads on cycles 0, 1, 2 to words holding 1, 2, 3.
  - Response: `rdata_valid` high on cycles 3, 4, 5 with data 1, 2, 3.
- Reset mid-flight and stats:
  - Stimulus: with RD_LAT=3, assert reset for one cycle after a read request.
  - Response: no `rdata_valid` after reset release.
  - Stats (`DSRAM_STATS_EN`): counters read 0 after reset; 2 reads + 1 write give `stat_rd_cnt`=2, `stat_wr_cnt`=1.
